apb_reg_subordinate: RTL

- APB completer (subordinate) that sits on one select line driven by the APB manager.
- Decodes the manager's setup/access phases and inserts a parameterised number of wait states.
- Holds a small bank of byte-strobed registers, one read-only ID register, and flags errors on bad accesses.
- Register contents are exported flat to the surrounding fabric.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_strb_merge.sv | 20 ++
 rtl/apb_reg_subordinate.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_pkg : shared types and sizing helpers for APB peripherals     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_sub_state_t;

    // Reason a transfer was answered with an error; kept visible for debug.
    typedef enum logic [2:0] {
        ERR_OK    = 3'd0,
        ERR_RANGE = 3'd1,
        ERR_ALIGN = 3'd2,
        ERR_RO    = 3'd3,
        ERR_PRIV  = 3'd4
    } apb_err_cause_t;

    localparam int c_strb_width = 32 / 8;
    localparam int c_idx_width  = $clog2(8);

    function automatic int f_strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int f_idx_width(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_strb_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_strb_merge : byte-lane merge of new data over old data       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module apb_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old_data,
    input  logic [DATA_WIDTH-1:0]   i_new_data,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_merged
);

    for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_lane
        assign o_merged[b*8 +: 8] = i_strb[b] ? i_new_data[b*8 +: 8] : i_old_data[b*8 +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/apb_reg_subordinate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_reg_subordinate : APB completer with wait states, a byte-    |
// | strobed register bank, a read-only ID register and error decode  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module apb_reg_subordinate
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0]           ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sel,
    input  logic                           enable,
    input  logic                           write,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [2:0]                     prot,
    input  logic [DATA_WIDTH-1:0]          wData,
    input  logic [DATA_WIDTH/8-1:0]        strb,
    output logic                           ready,
    output logic [DATA_WIDTH-1:0]          rData,
    output logic                           subError,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regsOut
);

    localparam int                    c_strb_width = f_strb_width(DATA_WIDTH);
    localparam int                    c_idx_width  = f_idx_width(NUM_REGS);
    localparam int                    c_align_bits = $clog2(c_strb_width);
    localparam logic [ADDR_WIDTH-1:0] c_span       = ADDR_WIDTH'(NUM_REGS * c_strb_width);
    localparam logic [3:0]            c_wait_init  = 4'(WAIT_STATES);

    apb_sub_state_t              r_state;
    logic [3:0]                  r_wait_cnt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        r_write;
    logic                        r_priv;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic [c_strb_width-1:0]     r_strb;
    logic                        r_ready;
    logic [DATA_WIDTH-1:0]       r_rdata;
    logic                        r_suberr;

    logic [ADDR_WIDTH-1:0]       w_dec_addr;
    logic                        w_dec_write;
    logic                        w_dec_priv;
    logic [ADDR_WIDTH-1:0]       w_offset;
    logic [c_idx_width-1:0]      w_idx;
    apb_err_cause_t              w_err_cause;
    logic                        w_err;
    logic [DATA_WIDTH-1:0]       w_bank [NUM_REGS];
    logic [DATA_WIDTH-1:0]       w_rd_word;
    logic [DATA_WIDTH-1:0]       w_rdata_resp;
    logic [DATA_WIDTH-1:0]       w_merged;
    logic                        w_commit;
    logic                        w_unused_prot;

    assign w_unused_prot = ^prot[2:1];

    // In IDLE the decode looks at the live bus so a zero-wait transfer can
    // answer on the setup edge; in ACCESS only the captured fields count.
    assign w_dec_addr  = (r_state == IDLE) ? addr    : r_addr;
    assign w_dec_write = (r_state == IDLE) ? write   : r_write;
    assign w_dec_priv  = (r_state == IDLE) ? prot[0] : r_priv;

    assign w_offset = w_dec_addr - BASE_ADDR;
    assign w_idx    = w_offset[c_align_bits +: c_idx_width];

    always_comb begin
        w_err_cause = ERR_OK;
        if ((w_dec_addr < BASE_ADDR) || (w_offset >= c_span)) begin
            w_err_cause = ERR_RANGE;
        end else if (|w_offset[c_align_bits-1:0]) begin
            w_err_cause = ERR_ALIGN;
        end else if (w_dec_write && (w_idx == '0)) begin
            w_err_cause = ERR_RO;
        end else if (w_dec_write && !w_dec_priv) begin
            w_err_cause = ERR_PRIV;
        end
    end

    assign w_err = (w_err_cause != ERR_OK);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == c_idx_width'(i)) begin
                w_rd_word = w_bank[i];
            end
        end
    end

    assign w_rdata_resp = (!w_dec_write && !w_err) ? w_rd_word : '0;

    apb_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .i_old_data (w_rd_word),
        .i_new_data (r_wdata),
        .i_strb     (r_strb),
        .o_merged   (w_merged)
    );

    // Commit on the APB completion edge: ready already high and the manager
    // still presenting the access phase.
    assign w_commit = (r_state == ACCESS) && sel && enable && r_ready && r_write && !w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_priv     <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_suberr   <= 1'b0;
        end else begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_suberr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sel && !enable) begin
                        r_addr     <= addr;
                        r_write    <= write;
                        r_priv     <= prot[0];
                        r_wdata    <= wData;
                        r_strb     <= strb;
                        r_wait_cnt <= c_wait_init;
                        r_state    <= ACCESS;
                        if (c_wait_init == 4'd0) begin
                            r_ready  <= 1'b1;
                            r_suberr <= w_err;
                            r_rdata  <= w_rdata_resp;
                        end
                    end
                end
                ACCESS: begin
                    if (!sel) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= 4'd0;
                    end else if (r_ready) begin
                        r_state <= IDLE;
                    end else if (r_wait_cnt > 4'd1) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_wait_cnt <= 4'd0;
                        r_ready    <= 1'b1;
                        r_suberr   <= w_err;
                        r_rdata    <= w_rdata_resp;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_bank[0] = DATA_WIDTH'(ID_VALUE);

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (w_commit && (w_idx == c_idx_width'(i))) begin
                r_q <= w_merged;
            end
        end

        assign w_bank[i] = r_q;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regsOut[i*DATA_WIDTH +: DATA_WIDTH] = w_bank[i];
    end

    assign ready    = r_ready;
    assign rData    = r_rdata;
    assign subError = r_suberr;

endmodule
`default_nettype wire
